aes256_key_scheduler: RTL and testbench

Sequential AES-256 key schedule per FIPS-197. Accepts a 256-bit cipher key through a valid/ready handshake and computes one 256-bit expansion step (8 words) per clock. Stores all 15 128-bit round keys in an internal register file. The round/cipher datapath downstream reads them through a registered read port.

---
 rtl/aes256_key_scheduler.sv | 174 +++++++++++++++++
 tb/tb_aes256_key_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_scheduler.sv
// rtl/aes256_key_scheduler.sv - AES-256 key schedule, one 8-word step per clock, 15-entry round-key file (optional AES_KS_ZEROIZE_EN)
module aes256_key_scheduler #(
    parameter int NUM_RK = 15,
    parameter int IDX_W  = 4
) (
`ifdef AES_KS_ZEROIZE_EN
    input  logic               zeroize,
`endif
    input  logic               clk,
    input  logic               rst_n,
    input  logic [255:0]       key_in,
    input  logic               key_valid,
    output logic               key_ready,
    output logic               busy,
    output logic               done,
    output logic               keys_valid,
    input  logic               rk_rd_en,
    input  logic [IDX_W-1:0]   rk_rd_idx,
    output logic [127:0]       rk_rd_data
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bits [8*(255-b) +: 8]; 8*(255-b) is just {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TBL[base +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t         state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [255:0]   work_q, work_d;
    logic [127:0]   rk_q [NUM_RK];
    logic [127:0]   rk_d [NUM_RK];
    logic [127:0]   rd_data_q, rd_data_d;
    logic           key_ready_q, key_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           keys_valid_q, keys_valid_d;
    logic           zero_req;
    logic           accept;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign key_ready  = key_ready_q & ~zero_req;
    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rk_rd_data = rd_data_q;
    assign accept     = key_valid & key_ready;

    logic [31:0]      p0, p1, p2, p3, p4, p5, p6, p7;
    logic [31:0]      t, u, n0, n1, n2, n3, n4, n5, n6, n7;
    logic [7:0]       rcon;
    logic [IDX_W-1:0] wr_lo, wr_hi;

    always_comb begin
        {p0, p1, p2, p3, p4, p5, p6, p7} = work_q;
        rcon = 8'h01 << (step_q - 3'd1);
        t  = sub_word({p7[23:0], p7[31:24]}) ^ {rcon, 24'h0};
        n0 = p0 ^ t;
        n1 = p1 ^ n0;
        n2 = p2 ^ n1;
        n3 = p3 ^ n2;
        u  = sub_word(n3);
        n4 = p4 ^ u;
        n5 = p5 ^ n4;
        n6 = p6 ^ n5;
        n7 = p7 ^ n6;
        wr_lo = IDX_W'({step_q, 1'b0});
        wr_hi = IDX_W'({step_q, 1'b1});
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        work_d       = work_q;
        rk_d         = rk_q;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;

        // Read samples rk_q, so a same-edge write is not visible until the next read.
        if (rk_rd_en) begin
            if (int'(rk_rd_idx) < NUM_RK) rd_data_d = rk_q[rk_rd_idx];
            else                          rd_data_d = '0;
        end

        case (state_q)
            IDLE, READY: begin
                if (accept) begin
                    rk_d[0]      = key_in[255:128];
                    rk_d[1]      = key_in[127:0];
                    work_d       = key_in;
                    step_d       = 3'd1;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                work_d      = {n0, n1, n2, n3, n4, n5, n6, n7};
                rk_d[wr_lo] = {n0, n1, n2, n3};
                if (step_q != 3'd7) begin
                    rk_d[wr_hi] = {n4, n5, n6, n7};
                    step_d      = step_q + 3'd1;
                end else begin
                    step_d       = 3'd0;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                    state_d      = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        if (zero_req) begin
            for (int i = 0; i < NUM_RK; i++) rk_d[i] = '0;
            work_d       = '0;
            rd_data_d    = '0;
            step_d       = 3'd0;
            done_d       = 1'b0;
            keys_valid_d = 1'b0;
            state_d      = IDLE;
        end

        key_ready_d = (state_d != EXPAND);
        busy_d      = (state_d == EXPAND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_q       <= 3'd0;
            work_q       <= '0;
            for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
            rd_data_q    <= '0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            work_q       <= work_d;
            rk_q         <= rk_d;
            rd_data_q    <= rd_data_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
        end
    end

endmodule

// File: tb/tb_aes256_key_scheduler.sv
// tb/tb_aes256_key_scheduler.sv - self-checking bench for aes256_key_scheduler against a word-level FIPS-197 model
module tb_aes256_key_scheduler;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_valid;
    logic         key_ready, busy, done, keys_valid;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [15];

    aes256_key_scheduler dut (
`ifdef AES_KS_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_rd_en   (rk_rd_en),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv; r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_m[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic model_schedule(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)      t = m_subw({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4) t = m_subw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic read_rk(input int idx, output logic [127:0] data);
        @(negedge clk);
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'(idx);
        @(negedge clk);
        rk_rd_en  = 1'b0;
        data      = rk_rd_data;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept_key(input logic [255:0] key, output int lat);
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready got=%b exp=1", key_ready);
        end
        key_in    = key;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_accept got=%b exp=1", busy);
        end
        wait_done(lat);
    endtask

    task automatic check_latency(input int lat);
        checks++;
        if (lat != 7) begin
            errors++; $display("FAIL done_latency got=%0d exp=7", lat);
        end
        checks++;
        if (keys_valid !== 1'b1) begin
            errors++; $display("FAIL keys_valid_at_done got=%b exp=1", keys_valid);
        end
    endtask

    task automatic check_schedule();
        logic [127:0] d;
        for (int r = 0; r < 15; r++) begin
            read_rk(r, d);
            checks++;
            if (d !== exp_rk[r]) begin
                errors++; $display("FAIL rk_read idx=%0d got=%h exp=%h", r, d, exp_rk[r]);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [127:0] d;
        for (int r = 0; r < 15; r++) begin
            read_rk(r, d);
            checks++;
            if (d !== 128'h0) begin
                errors++; $display("FAIL %s idx=%0d got=%h exp=0", tag, r, d);
            end
        end
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] d;
        checks++;
        if (keys_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++; $display("FAIL idle_flags got kv=%b kr=%b exp kv=0 kr=1", keys_valid, key_ready);
        end
        model_schedule(KEY_A3);
        accept_key(KEY_A3, lat);
        check_latency(lat);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
        read_rk(2, d);
        checks++;
        if (d !== A3_RK2) begin
            errors++; $display("FAIL a3_rk2 got=%h exp=%h", d, A3_RK2);
        end
        read_rk(14, d);
        checks++;
        if (d !== A3_RK14) begin
            errors++; $display("FAIL a3_rk14 got=%h exp=%h", d, A3_RK14);
        end
        check_schedule();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || keys_valid !== 1'b0 || rk_rd_data !== 128'h0) begin
            errors++;
            $display("FAIL async_reset got kr=%b busy=%b done=%b kv=%b rd=%h exp 1 0 0 0 0",
                     key_ready, busy, done, keys_valid, rk_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset_rk");
    endtask

    task automatic test_back_to_back();
        logic [255:0] k1, k2;
        int n, lat;
        k1 = rand_key();
        k2 = rand_key();
        model_schedule(k2);
        @(negedge clk);
        key_in    = k1;
        key_valid = 1'b1;
        @(negedge clk);
        key_in = k2;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            checks++;
            if (key_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL b2b_busy_phase cyc=%0d got kr=%b busy=%b exp 0 1", n, key_ready, busy);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 7 || keys_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_first_done got lat=%0d kv=%b exp 7 1", n, keys_valid);
        end
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_second_accept got kv=%b busy=%b exp 0 1", keys_valid, busy);
        end
        wait_done(lat);
        check_latency(lat);
        check_schedule();
    endtask

    task automatic test_read_boundaries();
        logic [127:0] d;
        int lat;
        read_rk(5, d);
        @(negedge clk);
        rk_rd_en  = 1'b0;
        rk_rd_idx = 4'd2;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rk_rd_data !== exp_rk[5]) begin
            errors++; $display("FAIL rd_en_low_hold got=%h exp=%h", rk_rd_data, exp_rk[5]);
        end
        read_rk(15, d);
        checks++;
        if (d !== 128'h0) begin
            errors++; $display("FAIL rd_idx15 got=%h exp=0", d);
        end
        model_schedule(256'h0);
        accept_key(256'h0, lat);
        check_latency(lat);
        read_rk(0, d);
        checks++;
        if (d !== 128'h0) begin
            errors++; $display("FAIL zero_key_rk0 got=%h exp=0", d);
        end
        read_rk(1, d);
        checks++;
        if (d !== 128'h0) begin
            errors++; $display("FAIL zero_key_rk1 got=%h exp=0", d);
        end
        check_schedule();
    endtask

    task automatic test_reset_mid_expand();
        int lat;
        @(negedge clk);
        key_in    = KEY_A3;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (keys_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags got kv=%b busy=%b exp 0 0", keys_valid, busy);
        end
        check_all_zero("mid_reset_rk");
        model_schedule(KEY_A3);
        accept_key(KEY_A3, lat);
        check_latency(lat);
        check_schedule();
    endtask

    task automatic test_random();
        logic [255:0] k;
        int lat;
        for (int i = 0; i < 4; i++) begin
            k = rand_key();
            model_schedule(k);
            accept_key(k, lat);
            check_latency(lat);
            check_schedule();
        end
    endtask

`ifdef AES_KS_ZEROIZE_EN
    task automatic test_zeroize();
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        checks++;
        if (keys_valid !== 1'b0 || rk_rd_data !== 128'h0) begin
            errors++; $display("FAIL zeroize_flags got kv=%b rd=%h exp 0 0", keys_valid, rk_rd_data);
        end
        check_all_zero("zeroize_rk");
        @(negedge clk);
        zeroize   = 1'b1;
        key_in    = KEY_A3;
        key_valid = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin
            errors++; $display("FAIL zeroize_ready got=%b exp=0", key_ready);
        end
        @(negedge clk);
        zeroize   = 1'b0;
        key_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL zeroize_drops_accept got busy=%b exp=0", busy);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = '0;
`ifdef AES_KS_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        build_sbox();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_fips();
        test_reset();
        test_back_to_back();
        test_read_boundaries();
        test_reset_mid_expand();
        test_random();
`ifdef AES_KS_ZEROIZE_EN
        test_zeroize();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
